// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction-fetch / data-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } grant_src_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports; data has
// priority, but a fetch waiting through STARVE_LIMIT data grants wins next.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              stall_o
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    grant_src_e        grant_src;
    logic              starve;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    assign starve = if_req_i && (streak_q == STREAK_MAX);

    // Next-state, grant capture and completion latching
    always_comb begin
        state_d     = state_q;
        grant_src   = SRC_IF;
        streak_d    = streak_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        if_data_d   = if_data_q;
        dm_ack_d    = 1'b0;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (start_i && (dm_req_i || if_req_i)) begin
                    grant_src = (dm_req_i && !starve) ? SRC_DM : SRC_IF;
                    mem_en_d  = 1'b1;
                    if (grant_src == SRC_DM) begin
                        state_d     = GRANT_DM;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        // Only data grants that bypass a waiting fetch count
                        if (!if_req_i) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end else begin
                        state_d     = GRANT_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end
                end
            end
            GRANT_IF, GRANT_DM: begin
                if (mem_ack_i) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == GRANT_IF) begin
                        if_ack_d  = 1'b1;
                        if_data_d = mem_data_i;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = mem_data_i;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_data_q   <= '0;
            dm_ack_q    <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_data_q   <= if_data_d;
            dm_ack_q    <= dm_ack_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_wdata_q;
    assign if_ack_o     = if_ack_q;
    assign if_data_o    = if_data_q;
    assign dm_ack_o     = dm_ack_q;
    assign dm_rdata_o   = dm_rdata_q;

    // Stall is combinational so it drops in the ack cycle; forced low in reset
    assign stall_o = rst_i & ((if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a variable-latency memory model.
module tb_mem_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_data_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_ack_o;
    logic [31:0] dm_rdata_o;
    logic        mem_enable_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
    logic        stall_o;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] alt_addr;
        logic [31:0] lat;
        logic [31:0] exp_data;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] mem [logic [31:0]];
    int          lat_cfg  = 1;
    bit          mem_auto = 1'b1;
    bit          man_ack  = 1'b0;
    logic [31:0] man_data = 32'h0;
    int          mcnt     = 0;

    // Memory model: acks after lat_cfg enabled cycles, returns old contents
    always @(posedge clk_i) begin
        #1;
        if (mem_auto) begin
            mem_ack_i = 1'b0;
            if (mem_enable_o) begin
                mcnt++;
                if (mcnt >= lat_cfg) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
                    if (mem_write_o) mem[mem_addr_o] = mem_data_o;
                    mcnt = 0;
                end
            end else begin
                mcnt = 0;
            end
        end else begin
            mcnt       = 0;
            mem_ack_i  = man_ack;
            mem_data_i = man_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_enable"}, 32'(mem_enable_o), 32'h0);
        check({tag, "_mem_write"},  32'(mem_write_o),  32'h0);
        check({tag, "_mem_addr"},   mem_addr_o,        32'h0);
        check({tag, "_mem_data"},   mem_data_o,        32'h0);
        check({tag, "_if_ack"},     32'(if_ack_o),     32'h0);
        check({tag, "_if_data"},    if_data_o,         32'h0);
        check({tag, "_dm_ack"},     32'(dm_ack_o),     32'h0);
        check({tag, "_dm_rdata"},   dm_rdata_o,        32'h0);
        check({tag, "_stall"},      32'(stall_o),      32'h0);
    endtask

    task automatic wait_ack(input bit dm, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk_i); #1;
            seen = dm ? dm_ack_o : if_ack_o;
        end
    endtask

    // One complete access on one port, checked cycle by cycle
    task automatic run_access(input vec_t v, input int idx);
        int en_cyc  = 0;
        bit seen    = 1'b0;
        bit addr_ok = 1'b1;
        bit first   = 1'b1;
        string p;
        p = $sformatf("v%0d", idx);
        lat_cfg = int'(v.lat);
        if (v.is_dm) begin
            dm_req_i = 1'b1; dm_we_i = v.we; dm_addr_i = v.addr; dm_wdata_i = v.wdata;
        end else begin
            if_req_i = 1'b1; if_addr_i = v.addr;
        end
        for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge clk_i); #1;
            if (mem_enable_o) begin
                if (first) begin
                    check({p, "_write_strobe"}, 32'(mem_write_o), 32'(v.we));
                    if (v.we) check({p, "_mem_wdata"}, mem_data_o, v.wdata);
                    if (v.alt_addr != 32'h0) dm_addr_i = v.alt_addr;
                    first = 1'b0;
                end
                en_cyc++;
                if (mem_addr_o != v.addr) addr_ok = 1'b0;
            end
            if (v.is_dm ? dm_ack_o : if_ack_o) begin
                seen = 1'b1;
                check({p, "_data"}, v.is_dm ? dm_rdata_o : if_data_o, v.exp_data);
                check({p, "_stall_in_ack"}, 32'(stall_o), 32'h0);
            end
        end
        check({p, "_ack_seen"}, 32'(seen), 32'h1);
        check({p, "_enable_cycles"}, 32'(en_cyc), v.lat);
        check({p, "_addr_stable"}, 32'(addr_ok), 32'h1);
        dm_req_i = 1'b0;
        if_req_i = 1'b0;
        @(posedge clk_i); #1;
        check({p, "_ack_one_cycle"}, 32'(v.is_dm ? dm_ack_o : if_ack_o), 32'h0);
    endtask

    initial begin
        vec_t        vecs [8];
        vec_t        post_rst;
        bit          exp_dm [10];
        bit          seen;
        bit          prev_en;
        bit          done;
        int          ng;
        int          nacks;
        int          g0;

        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,    32'h0,  32'd4, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 32'h20,  32'h0,    32'h0,  32'd1, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'h100, 32'h55,   32'h0,  32'd2, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b0, 32'h100, 32'h0,    32'h0,  32'd3, 32'h00000055};
        vecs[4] = '{1'b0, 1'b0, 32'h20,  32'h0,    32'h0,  32'd1, 32'h12345678};
        vecs[5] = '{1'b1, 1'b1, 32'h40,  32'hA0A0, 32'h0,  32'd1, 32'h11110040};
        vecs[6] = '{1'b0, 1'b0, 32'h40,  32'h0,    32'h0,  32'd2, 32'h0000A0A0};
        vecs[7] = '{1'b1, 1'b0, 32'h40,  32'h0,    32'h80, 32'd4, 32'h0000A0A0};
        post_rst = '{1'b1, 1'b0, 32'h20, 32'h0,    32'h0,  32'd2, 32'h12345678};
        exp_dm   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        mem[32'h10]  = 32'hDEADBEEF;
        mem[32'h20]  = 32'h12345678;
        mem[32'h40]  = 32'h11110040;
        mem[32'h80]  = 32'h80808080;
        mem[32'h100] = 32'hCAFEF00D;

        rst_i = 1'b0; start_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = 32'h0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 8; i++) run_access(vecs[i], i);

        // Simultaneous fetch and data write: data first, fetch right after RESP
        lat_cfg = 1;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_wdata_i = 32'h55;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        prev_en = 1'b0; ng = 0; nacks = 0; g0 = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i); #1;
            if (mem_enable_o && !prev_en) begin
                if (ng == 0) begin
                    check("simul_first_addr",  mem_addr_o, 32'h100);
                    check("simul_first_write", 32'(mem_write_o), 32'h1);
                    check("simul_first_wdata", mem_data_o, 32'h55);
                    g0 = c;
                end else if (ng == 1) begin
                    check("simul_second_addr",  mem_addr_o, 32'h20);
                    check("simul_second_write", 32'(mem_write_o), 32'h0);
                    check("simul_gap", 32'(c - g0), 32'd3);
                end
                ng++;
            end
            prev_en = mem_enable_o;
            if (dm_ack_o) begin nacks++; dm_req_i = 1'b0; end
            if (if_ack_o) begin
                nacks++;
                check("simul_if_data", if_data_o, 32'h12345678);
                if_req_i = 1'b0;
            end
        end
        check("simul_grants", 32'(ng), 32'd2);
        check("simul_acks", 32'(nacks), 32'd2);

        // Starvation: both held; 4 data grants, then one fetch, repeating
        lat_cfg = 1;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
        if_req_i = 1'b1; if_addr_i = 32'h300;
        prev_en = 1'b0; ng = 0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(posedge clk_i); #1;
            if (mem_enable_o && !prev_en && ng < 10) begin
                check($sformatf("starve_grant%0d_is_dm", ng),
                      32'(mem_addr_o == 32'h200), 32'(exp_dm[ng]));
                ng++;
            end
            prev_en = mem_enable_o;
            if (ng == 10 && if_ack_o) begin
                if_req_i = 1'b0; dm_req_i = 1'b0; done = 1'b1;
            end
        end
        check("starve_grants", 32'(ng), 32'd10);
        check("starve_done", 32'(done), 32'h1);

        // start_i low blocks grants; raising it grants on the next edge
        start_i = 1'b0;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            check($sformatf("nostart%0d_enable", c), 32'(mem_enable_o), 32'h0);
            check($sformatf("nostart%0d_stall", c),  32'(stall_o), 32'h1);
        end
        start_i = 1'b1;
        @(posedge clk_i); #1;
        check("start_grant_enable", 32'(mem_enable_o), 32'h1);
        check("start_grant_addr", mem_addr_o, 32'h20);
        wait_ack(1'b1, seen);
        check("start_dm_ack", 32'(seen), 32'h1);
        check("start_dm_data", dm_rdata_o, 32'h12345678);
        dm_req_i = 1'b0;
        wait_ack(1'b0, seen);
        check("start_if_ack", 32'(seen), 32'h1);
        check("start_if_data", if_data_o, 32'hDEADBEEF);
        if_req_i = 1'b0;
        @(posedge clk_i); #1;

        // Reset mid-GRANT_DM, then a stale memory ack arrives in IDLE
        mem_auto = 1'b0;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk_i); #1;
            seen = mem_enable_o;
        end
        check("rst_grant_seen", 32'(seen), 32'h1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        rst_i = 1'b0; dm_req_i = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        man_data = 32'h99; man_ack = 1'b1;
        @(negedge clk_i);
        man_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            check($sformatf("late_ack%0d_dm_ack", c), 32'(dm_ack_o), 32'h0);
            check($sformatf("late_ack%0d_enable", c), 32'(mem_enable_o), 32'h0);
        end
        check("late_ack_rdata", dm_rdata_o, 32'h0);
        mem_auto = 1'b1;
        @(posedge clk_i); #1;
        run_access(post_rst, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one shared single-port main memory between the CPU's instruction-fetch port and data-memory port. It sits between the pipeline (IF stage and MEM stage) and the memory model. Data accesses have fixed priority, with an anti-starvation override for fetch. It raises a stall to the pipeline whenever a requester is waiting.

## Interface
Parameters:
- ADDR_W, 32, address width of both ports and memory
- DATA_W, 32, data width of both ports and memory
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (≥1)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- start_i  input  1  new grants are allowed only while high
- if_req_i  input  1  fetch request, held until if_ack_o
- if_addr_i  input  ADDR_W  fetch address
- if_ack_o  output  1  one-cycle fetch completion
- if_data_o  output  DATA_W  fetched word, valid with if_ack_o
- dm_req_i  input  1  data request, held until dm_ack_o
- dm_we_i  input  1  1 = write, 0 = read
- dm_addr_i  input  ADDR_W  data address
- dm_wdata_i  input  DATA_W  write data
- dm_ack_o  output  1  one-cycle data completion
- dm_rdata_o  output  DATA_W  read word, valid with dm_ack_o
- mem_enable_o  output  1  memory access in progress
- mem_write_o  output  1  memory write strobe
- mem_addr_o  output  ADDR_W  memory address
- mem_data_o  output  DATA_W  memory write data
- mem_data_i  input  DATA_W  memory read data
- mem_ack_i  input  1  memory completion, one cycle, variable latency
- stall_o  output  1  pipeline stall

## Operation
- FSM states:
  - IDLE → GRANT_DM if start_i & dm_req_i & !(if_req_i & streak==STARVE_LIMIT).
  - IDLE → GRANT_IF if start_i & if_req_i and data is not chosen.
  - Otherwise IDLE holds.
  - GRANT_x → RESP on mem_ack_i.
  - RESP → IDLE unconditionally.
- On the grant transition, the arbiter registers the request fields (addr, we, wdata) into the mem_* outputs. They are held stable for the whole GRANT state. Requester inputs may change after the grant without effect.
- mem_enable_o = 1 exactly in GRANT_IF and GRANT_DM.
- mem_write_o = dm_we_i captured at grant. It is always 0 for fetches.
- On mem_ack_i in GRANT_x:
  - mem_data_i is latched into if_data_o or dm_rdata_o (latched for writes too).
  - The matching ack is high for the one RESP cycle.
  - Data outputs hold their value until the next completion on that port.
- Starvation counter `streak` (0..STARVE_LIMIT, saturating):
  - +1 on each DM grant made while if_req_i=1.
  - Cleared on any IF grant.
  - Cleared on a DM grant made while if_req_i=0.
- stall_o = (if_req_i & !if_ack_o) | (dm_req_i & !dm_ack_o). This is combinational; it is low in a requester's ack cycle.
- start_i low: no grant from IDLE. An access already in flight completes normally.
- mem_ack_i is ignored in IDLE and in RESP.

## Timing
- Reset (async assert): state IDLE, streak 0, and every output 0.
- The first grant is possible at the first rising edge after rst_i goes high.
- Request sampled in IDLE at edge 0 → mem_enable_o high from edge 0.
- mem_ack_i sampled at edge k → ack_o and data valid in cycle k..k+1; mem_enable_o low from edge k.
- Minimum access time is 3 cycles from request to ack (memory latency 1). Throughput is 1 access per (latency + 2) cycles.
- RESP gives the acked requester one cycle to drop or replace its request before IDLE re-samples.
- Simultaneous if_req_i and dm_req_i in IDLE: DM wins unless streak==STARVE_LIMIT.
- Reset asserted mid-GRANT: the access is abandoned and the outputs go to 0 at once. A late mem_ack_i after reset is ignored in IDLE.

## Structure
- A shared package holds:
  - the state encoding (IDLE, GRANT_IF, GRANT_DM, RESP; 2 bits);
  - the grant-source constants (SRC_IF, SRC_DM).
- The streak width is $clog2(STARVE_LIMIT+1), computed locally.
- Single module; no sub-module is warranted.

## Test plan
- Fetch only, memory latency 4, addr 0x10 returns 0xDEADBEEF:
  - mem_enable_o is high 4 cycles;
  - if_ack_o is high 1 cycle with if_data_o=0xDEADBEEF;
  - stall_o is low in the ack cycle.
- Simultaneous fetch 0x20 and data write 0x100←0x55:
  - DM is granted first with mem_write_o=1 and mem_data_o=0x55;
  - IF is granted right after RESP;
  - there are exactly 2 acks.
- Starvation check, STARVE_LIMIT=4, dm_req_i kept asserted and if_req_i held:
  - 4 DM grants occur, then 1 IF grant, then DM resumes;
  - streak is back at 0 after the IF grant.
- start_i=0 with both requests high for 10 cycles: no mem_enable_o, stall_o=1 throughout.
- Raise start_i: the grant follows at the next edge.
- rst_i pulsed low mid-GRANT_DM, then mem_ack_i arrives 2 cycles after release:
  - all outputs are 0 during reset;
  - the ack is ignored and no dm_ack_o occurs;
  - the next request is served normally.
- Requester changes dm_addr_i from 0x40 to 0x80 one cycle after the grant: mem_addr_o stays 0x40 until completion.
